// File: rtl/circle_plotter_pkg.sv
// circle_plotter_pkg: shared screen constants, FSM states and octant index type
package circle_plotter_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam logic [2:0] BLACK = 3'b000;
  typedef enum logic [2:0] {IDLE, CLEAR, INIT, DRAW, STEP, DONE} circle_state_t;
  typedef logic [2:0] octant_t;
endpackage

// File: rtl/circle_plotter_if.sv
// circle_plotter_if: start/done drawing handshake plus VGA-adapter plot signals
interface circle_plotter_if;
  logic start;
  logic forced_early_clear;
  logic [2:0] colour;
  logic [7:0] centre_x;
  logic [6:0] centre_y;
  logic [7:0] diameter;
  logic done;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic vga_plot;
  modport master (
    output start, forced_early_clear, colour, centre_x, centre_y, diameter,
    input done, vga_x, vga_y, vga_colour, vga_plot
  );
  modport slave (
    input start, forced_early_clear, colour, centre_x, centre_y, diameter,
    output done, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/circle_octant_pixel.sv
// circle_octant_pixel: maps centre, offsets and octant index to a screen pixel with bounds flag
module circle_octant_pixel
  import circle_plotter_pkg::*;
(
  input  logic [7:0] cx,
  input  logic [6:0] cy,
  input  logic [6:0] off_x,
  input  logic [6:0] off_y,
  input  octant_t    oct,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic       in_bounds
);
  localparam logic signed [9:0] W10 = 10'(SCREEN_W);
  localparam logic signed [9:0] H10 = 10'(SCREEN_H);
  logic [6:0] a, b;
  logic signed [9:0] px, py;
  // odd octants swap the offsets; octants 2-5 mirror x, octants 4-7 mirror y
  always_comb begin
    a = oct[0] ? off_y : off_x;
    b = oct[0] ? off_x : off_y;
    px = (oct[2] ^ oct[1]) ? $signed({2'b0, cx}) - $signed({3'b0, a}) : $signed({2'b0, cx}) + $signed({3'b0, a});
    py = oct[2] ? $signed({3'b0, cy}) - $signed({3'b0, b}) : $signed({3'b0, cy}) + $signed({3'b0, b});
    in_bounds = (px >= 10'sd0) && (px < W10) && (py >= 10'sd0) && (py < H10);
    vga_x = px[7:0];
    vga_y = py[6:0];
  end
endmodule

// File: rtl/circle_plotter.sv
// circle_plotter: clears the screen then plots a Bresenham circle outline, one pixel per cycle
module circle_plotter
  import circle_plotter_pkg::*;
(
  input logic clk,
  input logic rst_n,
  circle_plotter_if.slave bus
);
  localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);
  circle_state_t state, next;
  logic [7:0] cx, clr_x;
  logic [6:0] cy, r, clr_y, off_x, off_y;
  logic [2:0] col;
  logic signed [9:0] crit, ncrit, ny10, nx10;
  octant_t oct;
  logic [6:0] ny;
  logic signed [7:0] nx;
  logic crit_pos, step_more, last_clear, in_bounds;
  logic [7:0] px;
  logic [6:0] py;
  circle_octant_pixel u_pix (
    .cx(cx), .cy(cy), .off_x(off_x), .off_y(off_y), .oct(oct),
    .vga_x(px), .vga_y(py), .in_bounds(in_bounds)
  );
  // midpoint step: new off_y, possibly decremented off_x, and the updated criterion
  always_comb begin
    crit_pos = crit > 10'sd0;
    ny = off_y + 7'd1;
    nx = crit_pos ? $signed({1'b0, off_x}) - 8'sd1 : $signed({1'b0, off_x});
    ny10 = $signed({3'b0, ny});
    nx10 = {{2{nx[7]}}, nx};
    ncrit = crit_pos ? crit + ((ny10 - nx10) <<< 1) + 10'sd1 : crit + (ny10 <<< 1) + 10'sd1;
    step_more = $signed({1'b0, ny}) <= nx;
    last_clear = (clr_x == X_LAST) && (clr_y == Y_LAST);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  // next-state logic
  always_comb begin
    next = state;
    unique case (state)
      IDLE:  next = bus.start ? CLEAR : IDLE;
      CLEAR: next = (bus.forced_early_clear || last_clear) ? INIT : CLEAR;
      INIT:  next = DRAW;
      DRAW:  next = (oct == 3'd7) ? STEP : DRAW;
      STEP:  next = step_more ? DRAW : DONE;
      DONE:  next = bus.start ? DONE : IDLE;
      default: next = IDLE;
    endcase
  end
  // plot outputs: black sweep in CLEAR, clipped outline pixel in DRAW, quiet otherwise
  always_comb begin
    bus.done = state == DONE;
    bus.vga_plot = (state == CLEAR) || (state == DRAW && in_bounds);
    bus.vga_x = (state == CLEAR) ? clr_x : (state == DRAW) ? px : 8'd0;
    bus.vga_y = (state == CLEAR) ? clr_y : (state == DRAW) ? py : 7'd0;
    bus.vga_colour = (state == DRAW) ? col : BLACK;
  end
  // datapath: latch request, sweep clear counters, run the circle iteration
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cx <= '0;
      cy <= '0;
      r <= '0;
      col <= '0;
      clr_x <= '0;
      clr_y <= '0;
      off_x <= '0;
      off_y <= '0;
      crit <= '0;
      oct <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        cx <= bus.centre_x;
        cy <= bus.centre_y;
        r <= bus.diameter[7:1];
        col <= bus.colour;
        clr_x <= '0;
        clr_y <= '0;
      end
      if (state == CLEAR) begin
        clr_y <= (clr_y == Y_LAST) ? 7'd0 : clr_y + 7'd1;
        clr_x <= (clr_y == Y_LAST) ? clr_x + 8'd1 : clr_x;
      end
      if (state == INIT) begin
        off_x <= r;
        off_y <= '0;
        crit <= 10'sd1 - $signed({3'b0, r});
        oct <= '0;
      end
      if (state == DRAW) oct <= oct + 3'd1;
      if (state == STEP) begin
        off_y <= ny;
        off_x <= nx[6:0];
        crit <= ncrit;
      end
    end
endmodule

// File: tb/tb_circle_plotter.sv
// tb_circle_plotter: scoreboard bench for the circle plotter
module tb_circle_plotter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  circle_plotter_if bus();
  circle_plotter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {int x; int y; int c;} px_t;
  px_t q[$];
  int tests = 0;
  int fails = 0;
  int k;
  task automatic check(string name, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic push(int x, int y, int c);
    px_t p;
    p.x = x;
    p.y = y;
    p.c = c;
    q.push_back(p);
  endtask
  task automatic expect_clear(bit early);
    if (early) push(0, 0, 0);
    else for (int x = 0; x < 160; x++) for (int y = 0; y < 120; y++) push(x, y, 0);
  endtask
  task automatic expect_circle(int cx, int cy, int r, int c, output int iters);
    int ox, oy, d, dx, dy;
    ox = r;
    oy = 0;
    d = 1 - r;
    iters = 0;
    do begin
      iters++;
      for (int o = 0; o < 8; o++) begin
        case (o)
          0: begin dx = ox;  dy = oy;  end
          1: begin dx = oy;  dy = ox;  end
          2: begin dx = -ox; dy = oy;  end
          3: begin dx = -oy; dy = ox;  end
          4: begin dx = -ox; dy = -oy; end
          5: begin dx = -oy; dy = -ox; end
          6: begin dx = ox;  dy = -oy; end
          default: begin dx = oy; dy = -ox; end
        endcase
        if (cx + dx >= 0 && cx + dx < 160 && cy + dy >= 0 && cy + dy < 120) push(cx + dx, cy + dy, c);
      end
      oy++;
      if (d <= 0) d += 2 * oy + 1;
      else begin
        ox--;
        d += 2 * (oy - ox) + 1;
      end
    end while (oy <= ox);
  endtask
  task automatic monitor();
    px_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.vga_plot) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL plot_unexpected got (%0d,%0d) colour %0d expected no plot", bus.vga_x, bus.vga_y, bus.vga_colour);
        end else begin
          e = q.pop_front();
          if (bus.vga_x != e.x || bus.vga_y != e.y || bus.vga_colour != e.c) begin
            fails++;
            $display("FAIL plot got (%0d,%0d) colour %0d expected (%0d,%0d) colour %0d",
                     bus.vga_x, bus.vga_y, bus.vga_colour, e.x, e.y, e.c);
          end
        end
      end
    end
  endtask
  task automatic run(string name, int cx, int cy, int d, int c, bit early, int exp_edges, int hold);
    int n;
    bus.centre_x = 8'(cx);
    bus.centre_y = 7'(cy);
    bus.diameter = 8'(d);
    bus.colour = 3'(c);
    bus.forced_early_clear = early;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.centre_x = 8'(cx + 37);
    bus.centre_y = 7'(cy + 11);
    bus.diameter = 8'(d + 50);
    bus.colour = ~3'(c);
    n = 0;
    while (!bus.done && n < 30000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_edges_to_done"}, n, exp_edges);
    @(negedge clk);
    check({name, "_pending_plots"}, q.size(), 0);
    repeat (hold) @(posedge clk);
    #1;
    check({name, "_done_held"}, int'(bus.done), 1);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check({name, "_done_drop"}, int'(bus.done), 0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.forced_early_clear = 1'b0;
    bus.colour = '0;
    bus.centre_x = '0;
    bus.centre_y = '0;
    bus.diameter = '0;
    fork
      monitor();
    join_none
    #12;
    check("rst_done", int'(bus.done), 0);
    check("rst_plot", int'(bus.vga_plot), 0);
    check("rst_x", int'(bus.vga_x), 0);
    check("rst_y", int'(bus.vga_y), 0);
    check("rst_colour", int'(bus.vga_colour), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_done", int'(bus.done), 0);
    expect_clear(1'b0);
    bus.centre_x = 8'd80;
    bus.centre_y = 7'd60;
    bus.diameter = 8'd80;
    bus.colour = 3'd5;
    bus.start = 1'b1;
    @(posedge clk);
    repeat (499) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_done", int'(bus.done), 0);
    check("midrst_plot", int'(bus.vga_plot), 0);
    check("midrst_x", int'(bus.vga_x), 0);
    check("midrst_y", int'(bus.vga_y), 0);
    q.delete();
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_done", int'(bus.done), 0);
    check("post_rst_plot", int'(bus.vga_plot), 0);
    expect_clear(1'b0);
    expect_circle(80, 60, 40, 5, k);
    run("full", 80, 60, 80, 5, 1'b0, 19201 + 9 * k, 0);
    expect_clear(1'b1);
    push(81, 60, 3); push(80, 61, 3); push(79, 60, 3); push(80, 61, 3);
    push(79, 60, 3); push(80, 59, 3); push(81, 60, 3); push(80, 59, 3);
    push(81, 61, 3); push(81, 61, 3); push(79, 61, 3); push(79, 61, 3);
    push(79, 59, 3); push(79, 59, 3); push(81, 59, 3); push(81, 59, 3);
    run("d2", 80, 60, 2, 3, 1'b1, 20, 20);
    expect_clear(1'b1);
    repeat (8) push(10, 10, 6);
    run("d0", 10, 10, 0, 6, 1'b1, 11, 0);
    expect_clear(1'b1);
    expect_circle(150, 5, 20, 7, k);
    run("clip", 150, 5, 40, 7, 1'b1, 2 + 9 * k, 3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
